// File: rtl/axil_sram_slave.sv
// AXI4-Lite responder over a 2^MEM_AW x 32-bit word store, serving one transaction at a time
// with programmable read and write-response latency.
module axil_sram_slave #(
   parameter int unsigned MEM_AW    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned WR_LAT    = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   input  logic [31:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready
);

   localparam int unsigned DEPTH  = 1 << MEM_AW;
   localparam logic [3:0]  RD_CNT = 4'(RD_LAT - 1);
   localparam logic [3:0]  WR_CNT = 4'(WR_LAT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_WAIT   = 3'd1,
      RD_RESP   = 3'd2,
      WR_COMMIT = 3'd3,
      WR_WAIT   = 3'd4,
      WR_RESP   = 3'd5
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        aw_held_q, w_held_q, last_wr_q;
   logic        aw_held_d, w_held_d;
   logic [31:0] awaddr_q, wdata_q, araddr_q;
   logic [3:0]  wstrb_q;
   logic        bvalid_q, rvalid_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;
   logic [31:0] mem_q [0:DEPTH-1];

   logic              idle_s, aw_hs_s, w_hs_s, ar_hs_s;
   logic [1:0]        rd_resp_s, wr_resp_s;
   logic [MEM_AW-1:0] rd_idx_s, wr_idx_s;

   // Out of window -> DECERR; in window but unaligned -> SLVERR. BASE_ADDR is window-aligned.
   function automatic logic [1:0] decode_resp(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      if ((off >> (MEM_AW + 2)) != 32'd0) begin
         decode_resp = 2'b11;
      end else if (addr[1:0] != 2'b00) begin
         decode_resp = 2'b10;
      end else begin
         decode_resp = 2'b00;
      end
   endfunction

   assign idle_s    = (state_q == IDLE) && !i_rst;
   assign s_awready = idle_s && !aw_held_q;
   assign s_wready  = idle_s && !w_held_q;
   assign s_arready = idle_s && !aw_held_q && !w_held_q && (!s_awvalid || last_wr_q);

   assign aw_hs_s   = s_awvalid && s_awready;
   assign w_hs_s    = s_wvalid && s_wready;
   assign ar_hs_s   = s_arvalid && s_arready;
   assign aw_held_d = aw_held_q || aw_hs_s;
   assign w_held_d  = w_held_q || w_hs_s;

   assign rd_resp_s = decode_resp(araddr_q);
   assign wr_resp_s = decode_resp(awaddr_q);
   assign rd_idx_s  = araddr_q[MEM_AW+1:2];
   assign wr_idx_s  = awaddr_q[MEM_AW+1:2];

   assign s_bresp  = bresp_q;
   assign s_bvalid = bvalid_q;
   assign s_rresp  = rresp_q;
   assign s_rdata  = rdata_q;
   assign s_rvalid = rvalid_q;

   // Transaction FSM with registered response channels.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         last_wr_q <= 1'b0;
         awaddr_q  <= 32'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         araddr_q  <= 32'd0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (aw_hs_s) begin
                  aw_held_q <= 1'b1;
                  awaddr_q  <= s_awaddr;
               end
               if (w_hs_s) begin
                  w_held_q <= 1'b1;
                  wdata_q  <= s_wdata;
                  wstrb_q  <= s_wstrb;
               end
               // A read can only handshake when nothing is held, so it always wins that cycle.
               if (ar_hs_s) begin
                  araddr_q <= s_araddr;
                  cnt_q    <= RD_CNT;
                  state_q  <= RD_WAIT;
               end else if (aw_held_d && w_held_d) begin
                  state_q <= WR_COMMIT;
               end
            end
            RD_WAIT: begin
               if (cnt_q == 4'd0) begin
                  rresp_q  <= rd_resp_s;
                  rdata_q  <= (rd_resp_s == 2'b00) ? mem_q[rd_idx_s] : 32'd0;
                  rvalid_q <= 1'b1;
                  state_q  <= RD_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RD_RESP: begin
               if (s_rready) begin
                  rvalid_q  <= 1'b0;
                  last_wr_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            WR_COMMIT: begin
               aw_held_q <= 1'b0;
               w_held_q  <= 1'b0;
               bresp_q   <= wr_resp_s;
               cnt_q     <= WR_CNT;
               state_q   <= WR_WAIT;
            end
            WR_WAIT: begin
               if (cnt_q == 4'd0) begin
                  bvalid_q <= 1'b1;
                  state_q  <= WR_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            WR_RESP: begin
               if (s_bready) begin
                  bvalid_q  <= 1'b0;
                  last_wr_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Byte-lane store update at commit; contents deliberately survive reset.
   always_ff @(posedge i_clk) begin
      if ((state_q == WR_COMMIT) && (wr_resp_s == 2'b00)) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
               mem_q[wr_idx_s][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Scoreboard bench for axil_sram_slave: directed transactions push expected responses,
// a negedge monitor pops and compares every R/B handshake.
module tb_axil_sram_slave;

   localparam int unsigned MEM_AW = 12;
   localparam int unsigned RD_LAT = 3;
   localparam int unsigned WR_LAT = 4;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] s_awaddr = 32'd0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [31:0] s_wdata = 32'd0;
   logic [3:0]  s_wstrb = 4'd0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready = 1'b1;
   logic [31:0] s_araddr = 32'd0;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready = 1'b1;

   typedef struct {
      bit          is_rd;
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   axil_sram_slave #(
      .MEM_AW(MEM_AW), .BASE_ADDR(32'h8000_0000), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_rsp(input bit is_rd, input logic [1:0] resp, input logic [31:0] data);
      exp_t e;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_%s: resp %b data %h with nothing expected",
                  is_rd ? "r" : "b", resp, data);
      end else begin
         e = sb_q.pop_front();
         if (e.is_rd != is_rd || e.resp !== resp || (is_rd && e.data !== data)) begin
            n_err++;
            $display("FAIL resp_%s: got %s resp %b data %h, expected %s resp %b data %h",
                     is_rd ? "r" : "b", is_rd ? "R" : "B", resp, data,
                     e.is_rd ? "R" : "B", e.resp, e.data);
         end
      end
   endtask

   // Response monitor: every R or B handshake is checked against the scoreboard.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (s_rvalid && s_rready) check_rsp(1'b1, s_rresp, s_rdata);
         if (s_bvalid && s_bready) check_rsp(1'b0, s_bresp, 32'd0);
      end
   end

   task automatic push(input bit is_rd, input logic [1:0] resp, input logic [31:0] data);
      exp_t e;
      e.is_rd = is_rd;
      e.resp  = resp;
      e.data  = data;
      sb_q.push_back(e);
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 200) begin
         @(posedge i_clk);
         t++;
      end
      #1;
      n_vec++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Entered one step after a rising edge; AW and W are offered after aw_dly / w_dly cycles.
   task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                              input int aw_dly, input int w_dly);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      int t = 0;
      while (!(aw_done && w_done) && t < 100) begin
         s_awaddr  = a;
         s_wdata   = d;
         s_wstrb   = st;
         s_awvalid = !aw_done && (t >= aw_dly);
         s_wvalid  = !w_done && (t >= w_dly);
         @(negedge i_clk);
         if (s_awvalid && s_awready) aw_done = 1'b1;
         if (s_wvalid && s_wready) w_done = 1'b1;
         @(posedge i_clk);
         #1;
         t++;
      end
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      if (!(aw_done && w_done)) begin
         n_vec++;
         n_err++;
         $display("FAIL write_handshake: aw %0d w %0d, expected 1 1", aw_done, w_done);
      end
   endtask

   // Returns at the falling edge where rvalid is first seen; latency is checked against RD_LAT.
   task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      bit hs  = 1'b0;
      bit seen = 1'b0;
      int t   = 0;
      int lat = 0;
      push(1'b1, r, d);
      s_araddr  = a;
      s_arvalid = 1'b1;
      while (!hs && t < 100) begin
         @(negedge i_clk);
         if (s_arready) hs = 1'b1;
         @(posedge i_clk);
         #1;
         t++;
      end
      s_arvalid = 1'b0;
      while (!seen && lat < 50) begin
         @(negedge i_clk);
         if (s_rvalid) seen = 1'b1;
         else lat++;
      end
      chk("rd_latency", 32'(lat), 32'(RD_LAT));
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                     input logic [1:0] r);
      push(1'b0, r, 32'd0);
      issue_write(a, d, st, 0, 0);
      wait_drain();
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
      do_read(a, d, r);
      wait_drain();
   endtask

   initial begin
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
      chk("rst_valids", {30'd0, s_bvalid, s_rvalid}, 32'd0);
      chk("rst_resps", {28'd0, s_bresp, s_rresp}, 32'd0);
      chk("rst_rdata", s_rdata, 32'd0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      #1;
      chk("post_rst_ready", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
      @(posedge i_clk);
      #1;

      // Basic write then latency-checked read
      wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
      rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

      // W offered 4 cycles ahead of AW, partial strobe over all-ones
      wr(32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 2'b00);
      push(1'b0, 2'b00, 32'd0);
      issue_write(32'h8000_0000, 32'h1122_3344, 4'b0101, 4, 0);
      wait_drain();
      rd(32'h8000_0000, 32'hFF22_FF44, 2'b00);

      // Decode errors and window boundaries
      rd(32'h7FFF_FFFC, 32'd0, 2'b11);
      wr(32'h8000_0002, 32'h0000_0000, 4'hF, 2'b10);
      rd(32'h8000_0000, 32'hFF22_FF44, 2'b00);
      rd(32'h8000_4000, 32'd0, 2'b11);
      wr(32'h8000_3FFC, 32'h0BAD_CAFE, 4'hF, 2'b00);
      rd(32'h8000_3FFC, 32'h0BAD_CAFE, 2'b00);
      rd(32'h8000_0002, 32'd0, 2'b10);

      // Zero and single-lane strobes
      wr(32'h8000_0010, 32'h0000_0000, 4'h0, 2'b00);
      rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
      wr(32'h8000_0010, 32'h1200_0000, 4'b1000, 2'b00);
      rd(32'h8000_0010, 32'h12AD_BEEF, 2'b00);

      // Read response backpressure
      s_rready = 1'b0;
      do_read(32'h8000_0010, 32'h12AD_BEEF, 2'b00);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rvalid", {31'd0, s_rvalid}, 32'd1);
         chk("bp_rdata", s_rdata, 32'h12AD_BEEF);
         chk("bp_readies", {30'd0, s_arready, s_awready}, 32'd0);
         @(negedge i_clk);
      end
      s_rready = 1'b1;
      wait_drain();

      // Simultaneous AR and AW+W right after a write: read first, sees the old data
      wr(32'h8000_0020, 32'h5555_AAAA, 4'hF, 2'b00);
      push(1'b1, 2'b00, 32'h5555_AAAA);
      push(1'b0, 2'b00, 32'd0);
      s_araddr  = 32'h8000_0020;
      s_awaddr  = 32'h8000_0020;
      s_wdata   = 32'h0123_4567;
      s_wstrb   = 4'hF;
      s_arvalid = 1'b1;
      s_awvalid = 1'b1;
      s_wvalid  = 1'b1;
      @(negedge i_clk);
      chk("arb_readies", {29'd0, s_arready, s_awready, s_wready}, 32'd7);
      @(posedge i_clk);
      #1;
      s_arvalid = 1'b0;
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      wait_drain();
      rd(32'h8000_0020, 32'h0123_4567, 2'b00);

      // Reset while the write response is still counting down
      issue_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 0, 0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      #1;
      chk("midrst_async", {29'd0, s_awready, s_bvalid, s_arready}, 32'd0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      repeat (8) @(posedge i_clk);
      #1;
      chk("midrst_idle", {31'd0, s_awready}, 32'd1);
      rd(32'h8000_0030, 32'hCAFE_F00D, 2'b00);
      wr(32'h8000_0034, 32'h7654_3210, 4'hF, 2'b00);
      rd(32'h8000_0034, 32'h7654_3210, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axil_sram_slave.md
AXIL_SRAM_SLAVE -- requirements
Module: axil_sram_slave

Interface
REQ-001 Parameter MEM_AW, default 12, SHALL set the log2 of the memory depth in 32-bit words (4096 words, 16 KiB).
REQ-002 Parameter BASE_ADDR, default 32'h8000_0000, SHALL be the byte address of word 0; it SHALL be aligned to 4*2^MEM_AW.
REQ-003 Parameter RD_LAT, default 1, range 1..15, SHALL set the cycles from AR handshake to rvalid assertion.
REQ-004 Parameter WR_LAT, default 1, range 1..15, SHALL set the cycles from write commit to bvalid assertion.
REQ-005 Ports SHALL be as follows; the clock is single and the reset is asynchronous, active-high:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- s_awaddr  in  32  write address
- s_awvalid  in  1
- s_awready  out  1
- s_wdata  in  32
- s_wstrb  in  4  byte enables
- s_wvalid  in  1
- s_wready  out  1
- s_bresp  out  2
- s_bvalid  out  1
- s_bready  in  1
- s_araddr  in  32  read address
- s_arvalid  in  1
- s_arready  out  1
- s_rdata  out  32
- s_rresp  out  2
- s_rvalid  out  1
- s_rready  in  1

Function
REQ-006 The block SHALL be an AXI4-Lite responder backed by 2^MEM_AW x 32-bit storage, with one transaction in service at a time.
REQ-007 FSM states SHALL be IDLE, RD_WAIT, RD_RESP, WR_COMMIT, WR_WAIT, WR_RESP.
REQ-008 In IDLE, the AW and W channels SHALL each be captured independently into holding registers: s_awready = IDLE && !aw_held; s_wready = IDLE && !w_held.
REQ-009 s_arready SHALL be high in IDLE only when no AW or W is held and either s_awvalid is low or the last_wr flag is set.
REQ-010 last_wr SHALL be set on write completion and cleared on read completion, so that a read wins a simultaneous AR/AW after a write.
REQ-011 On the AR handshake, the block SHALL latch the address, load the delay counter with RD_LAT-1, and enter RD_WAIT.
REQ-012 In RD_WAIT, the block SHALL decrement the counter. At 0 it SHALL register s_rdata and s_rresp, set s_rvalid, and enter RD_RESP, giving rvalid exactly RD_LAT cycles after the handshake.
REQ-013 In RD_RESP, s_rvalid, s_rdata and s_rresp SHALL hold stable until s_rready; on the handshake, s_rvalid SHALL drop and the FSM SHALL return to IDLE.
REQ-014 When aw_held and w_held are both true (including when captured the same cycle), the FSM SHALL enter WR_COMMIT.
REQ-015 In WR_COMMIT, the block SHALL write each byte lane whose s_wstrb bit is 1, leave the others unchanged, clear both held flags, load the counter with WR_LAT-1, and enter WR_WAIT.
REQ-016 In WR_WAIT, the block SHALL count down. At 0 it SHALL set s_bvalid with the registered s_bresp and enter WR_RESP.
REQ-017 In WR_RESP, s_bvalid SHALL hold until s_bready; on the handshake, the FSM SHALL return to IDLE.
REQ-018 Address decode SHALL be as follows:
- addr - BASE_ADDR >= 4*2^MEM_AW: resp 2'b11 (DECERR); the write is dropped and rdata = 0.
- addr[1:0] != 0 with the address in range: resp 2'b10 (SLVERR); the write is dropped and rdata = 0.
- Otherwise: resp 2'b00 and word index = addr[MEM_AW+1:2].
REQ-019 Error responses SHALL use the same latency as OKAY responses.
REQ-020 s_wstrb = 4'b0000 to a valid address SHALL return OKAY and leave memory unchanged.
REQ-021 A read of a word written earlier SHALL return the post-write value; there are no read-during-write hazards, since only one transaction is active.

Reset
REQ-022 While i_rst is high, the block SHALL force the following asynchronously, independent of i_clk:
- FSM to IDLE
- counter, aw_held, w_held, last_wr to 0
- s_awready, s_wready, s_arready to 0 for the reset cycle, then per REQ-008/009
- s_bvalid, s_rvalid to 0
- s_bresp, s_rresp to 2'b00
- s_rdata to 0
REQ-023 Memory contents SHALL NOT be reset. A write already committed in WR_COMMIT SHALL persist; a write captured but not committed SHALL be discarded; an in-flight response SHALL be discarded.

Verification
REQ-024 Read latency: write 32'hDEAD_BEEF to 32'h8000_0010 with strb 4'hF, then read 32'h8000_0010 with RD_LAT=3 -> rvalid 3 cycles after the AR handshake, rdata 32'hDEAD_BEEF, rresp 2'b00.
REQ-025 W before AW: present W (32'h1122_3344, strb 4'b0101) 4 cycles before AW 32'h8000_0000 over prior value 32'hFFFF_FFFF -> one bvalid, OKAY, and a subsequent read returns 32'hFF22_FF44.
REQ-026 Error decode: read 32'h7FFF_FFFC -> rresp 2'b11, rdata 0; write 32'h8000_0002 -> bresp 2'b10 and memory unchanged; read 32'h8000_4000 (MEM_AW=12) -> 2'b11.
REQ-027 Backpressure and arbitration: hold rready low for 5 cycles in RD_RESP -> rvalid/rdata stable and s_arready/s_awready low. Then, after a completed write, present AR and AW+W in the same IDLE cycle -> the read is served first and the write follows.
REQ-028 Reset mid-write: assert i_rst for 1 cycle while in WR_WAIT (WR_LAT=4) -> bvalid never asserts for that write, the committed data is readable afterwards, and the next transaction completes normally.
